// File: rtl/nec_ir_tx_if.sv
// Request/response bundle between a frame source and the NEC infrared transmitter.
// The command byte pair and the envelope/LED drives travel together with the handshake.
interface nec_ir_tx_if;
   logic       start;
   logic       repeat_req;
   logic [7:0] address;
   logic [7:0] command;
   logic       ir_env;
   logic       ir_led;
   logic       busy;
   logic       done;

   modport master (
      output start, repeat_req, address, command,
      input  ir_env, ir_led, busy, done
   );

   modport slave (
      input  start, repeat_req, address, command,
      output ir_env, ir_led, busy, done
   );
endinterface

// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: leader, 32 data bits LSB first, stop mark and idle gap,
// or a short repeat code. Active-low envelope plus a carrier-gated LED drive.
module nec_ir_tx #(
   parameter int UNIT_CYC     = 28125,
   parameter int CARR_HALF    = 658,
   parameter int LEAD_MARK_U  = 16,
   parameter int LEAD_SPACE_U = 8,
   parameter int REP_SPACE_U  = 4,
   parameter int ONE_SPACE_U  = 3,
   parameter int GAP_U        = 72
) (
   input  logic       clk,
   input  logic       rst,
   nec_ir_tx_if.slave bus
);

   localparam int CW = $clog2(UNIT_CYC + 1);
   localparam int KW = $clog2(CARR_HALF + 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYC - 1);
   localparam logic [KW-1:0] CAR_LAST = KW'(CARR_HALF - 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LEAD_MARK  = 3'd1,
      S_LEAD_SPACE = 3'd2,
      S_BIT_MARK   = 3'd3,
      S_BIT_SPACE  = 3'd4,
      S_STOP_MARK  = 3'd5,
      S_GAP        = 3'd6
   } state_t;

   state_t          state_r, state_s;
   logic [CW-1:0]   cyc_cnt_r, cyc_cnt_s;
   logic [7:0]      unit_cnt_r, unit_cnt_s;
   logic [7:0]      units_s;
   logic [4:0]      bit_idx_r, bit_idx_s;
   logic [31:0]     shreg_r, shreg_s;
   logic            rep_flag_r, rep_flag_s;
   logic            env_r, env_s;
   logic            car_r, car_s;
   logic [KW-1:0]   car_cnt_r, car_cnt_s;
   logic            busy_r, busy_s;
   logic            done_r, done_s;
   logic            unit_last_s;
   logic            seg_last_s;

   // Frame word as sent on air: address, its inverse, command, its inverse.
   function automatic logic [31:0] nec_frame(input logic [7:0] addr, input logic [7:0] cmd);
      return {~cmd, cmd, ~addr, addr};
   endfunction

   function automatic logic is_mark(input state_t st);
      logic m;
      case (st)
         S_LEAD_MARK, S_BIT_MARK, S_STOP_MARK: m = 1'b1;
         default:                              m = 1'b0;
      endcase
      return m;
   endfunction

   // Next-state, segment timing, carrier divider and output decode.
   always_comb begin
      state_s    = state_r;
      cyc_cnt_s  = cyc_cnt_r;
      unit_cnt_s = unit_cnt_r;
      bit_idx_s  = bit_idx_r;
      shreg_s    = shreg_r;
      rep_flag_s = rep_flag_r;
      car_s      = car_r;
      car_cnt_s  = car_cnt_r;
      done_s     = 1'b0;
      units_s    = 8'd1;

      case (state_r)
         S_LEAD_MARK:  units_s = 8'(LEAD_MARK_U);
         S_LEAD_SPACE: units_s = rep_flag_r ? 8'(REP_SPACE_U) : 8'(LEAD_SPACE_U);
         S_BIT_SPACE:  units_s = shreg_r[bit_idx_r] ? 8'(ONE_SPACE_U) : 8'd1;
         S_GAP:        units_s = 8'(GAP_U);
         default:      units_s = 8'd1;
      endcase

      unit_last_s = (cyc_cnt_r == CYC_LAST);
      seg_last_s  = unit_last_s && (unit_cnt_r == (units_s - 8'd1));

      case (state_r)
         S_IDLE: begin
            if (bus.start) begin
               state_s    = S_LEAD_MARK;
               shreg_s    = nec_frame(bus.address, bus.command);
               rep_flag_s = 1'b0;
            end else if (bus.repeat_req) begin
               state_s    = S_LEAD_MARK;
               rep_flag_s = 1'b1;
            end else begin
               state_s    = S_IDLE;
            end
         end
         S_LEAD_MARK: begin
            if (seg_last_s) state_s = S_LEAD_SPACE;
            else            state_s = state_r;
         end
         S_LEAD_SPACE: begin
            if (seg_last_s && rep_flag_r) begin
               state_s = S_STOP_MARK;
            end else if (seg_last_s) begin
               state_s   = S_BIT_MARK;
               bit_idx_s = 5'd0;
            end else begin
               state_s = state_r;
            end
         end
         S_BIT_MARK: begin
            if (seg_last_s) state_s = S_BIT_SPACE;
            else            state_s = state_r;
         end
         S_BIT_SPACE: begin
            if (seg_last_s && (bit_idx_r == 5'd31)) begin
               state_s = S_STOP_MARK;
            end else if (seg_last_s) begin
               state_s   = S_BIT_MARK;
               bit_idx_s = bit_idx_r + 5'd1;
            end else begin
               state_s = state_r;
            end
         end
         S_STOP_MARK: begin
            if (seg_last_s) state_s = S_GAP;
            else            state_s = state_r;
         end
         S_GAP: begin
            if (seg_last_s) begin
               state_s = S_IDLE;
               done_s  = 1'b1;
            end else begin
               state_s = state_r;
            end
         end
         default: state_s = S_IDLE;
      endcase

      // Counters restart on every state change so segment lengths never drift.
      if ((state_s != state_r) || (state_r == S_IDLE)) begin
         cyc_cnt_s  = '0;
         unit_cnt_s = 8'd0;
      end else if (unit_last_s) begin
         cyc_cnt_s  = '0;
         unit_cnt_s = unit_cnt_r + 8'd1;
      end else begin
         cyc_cnt_s  = cyc_cnt_r + CW'(1);
         unit_cnt_s = unit_cnt_r;
      end

      if (is_mark(state_s) && !is_mark(state_r)) begin
         car_cnt_s = '0;
         car_s     = 1'b1;
      end else if (is_mark(state_s) && (car_cnt_r == CAR_LAST)) begin
         car_cnt_s = '0;
         car_s     = ~car_r;
      end else if (is_mark(state_s)) begin
         car_cnt_s = car_cnt_r + KW'(1);
         car_s     = car_r;
      end else begin
         car_cnt_s = '0;
         car_s     = 1'b0;
      end

      env_s  = ~is_mark(state_s);
      busy_s = (state_s != S_IDLE);
   end

   // State and registered outputs; reset aborts any frame without a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= S_IDLE;
         cyc_cnt_r  <= '0;
         unit_cnt_r <= 8'd0;
         bit_idx_r  <= 5'd0;
         shreg_r    <= 32'd0;
         rep_flag_r <= 1'b0;
         env_r      <= 1'b1;
         car_r      <= 1'b0;
         car_cnt_r  <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         cyc_cnt_r  <= cyc_cnt_s;
         unit_cnt_r <= unit_cnt_s;
         bit_idx_r  <= bit_idx_s;
         shreg_r    <= shreg_s;
         rep_flag_r <= rep_flag_s;
         env_r      <= env_s;
         car_r      <= car_s;
         car_cnt_r  <= car_cnt_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
      end
   end

   // car_r is already forced low in spaces, so it is the LED drive directly.
   assign bus.ir_env = env_r;
   assign bus.ir_led = car_r;
   assign bus.busy   = busy_r;
   assign bus.done   = done_r;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Directed bench for nec_ir_tx with small timing parameters; a segment-list model of
// the expected waveform is checked every cycle, plus hand-computed run lengths.
module tb_nec_ir_tx;
   localparam int U  = 4;
   localparam int CH = 3;
   localparam int GU = 2;

   typedef struct packed {
      logic env;
      logic led;
      logic busy;
      logic done;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_bad = 0;
   exp_t q[$];
   exp_t e_c;
   exp_t got_c;
   bit   m_idle;
   int   m_total;
   int   m_runs[8];

   always #5 clk = ~clk;

   nec_ir_tx_if bus();

   nec_ir_tx #(.UNIT_CYC(U), .CARR_HALF(CH), .GAP_U(GU)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic push_seg(input bit mark, input int cycles);
      exp_t e;
      for (int k = 0; k < cycles; k++) begin
         e.env  = !mark;
         e.led  = mark && (((k / CH) % 2) == 0);
         e.busy = 1'b1;
         e.done = 1'b0;
         q.push_back(e);
      end
   endtask

   task automatic build(input bit is_rep, input logic [31:0] data);
      exp_t e;
      push_seg(1'b1, 16 * U);
      push_seg(1'b0, (is_rep ? 4 : 8) * U);
      if (!is_rep) begin
         for (int i = 0; i < 32; i++) begin
            push_seg(1'b1, U);
            push_seg(1'b0, (data[i] ? 3 : 1) * U);
         end
      end
      push_seg(1'b1, U);
      push_seg(1'b0, GU * U);
      e.env = 1'b1; e.led = 1'b0; e.busy = 1'b0; e.done = 1'b1;
      q.push_back(e);
   endtask

   // Model: q[0] is the expected output vector for the current clock cycle.
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         m_idle = (q.size() == 0) || ((q.size() == 1) && q[0].done);
         if (q.size() > 0) void'(q.pop_front());
         if (m_idle && (bus.start || bus.repeat_req))
            build(!bus.start, {~bus.command, bus.command, ~bus.address, bus.address});
      end
   end

   always @(negedge clk) begin
      if (q.size() > 0) e_c = q[0];
      else              e_c = 4'b1000;
      got_c = {bus.ir_env, bus.ir_led, bus.busy, bus.done};
      n_vec++;
      if (got_c !== e_c) begin
         n_bad++;
         $display("FAIL cycle t=%0t env/led/busy/done got %b required %b", $time, got_c, e_c);
      end
   end

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got %0d required %0d", name, got, exp);
      end
   endtask

   task automatic pulse(input bit now, input bit s, input bit r,
                        input logic [7:0] a, input logic [7:0] c);
      if (!now) @(negedge clk);
      bus.start = s; bus.repeat_req = r; bus.address = a; bus.command = c;
      @(negedge clk);
      bus.start = 1'b0; bus.repeat_req = 1'b0;
   endtask

   // Counts busy cycles and envelope run lengths until done, bounded.
   task automatic wait_done(input int bound);
      int   idx;
      logic prev;
      bit   seen;
      idx = 0; prev = 1'b1; seen = 1'b0; m_total = 0;
      for (int j = 0; j < 8; j++) m_runs[j] = 0;
      for (int i = 0; i < bound; i++) begin
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy === 1'b1) begin
            if ((m_total > 0) && (bus.ir_env !== prev)) idx++;
            if (idx < 8) m_runs[idx]++;
            prev = bus.ir_env;
            m_total++;
         end
         @(negedge clk);
      end
      n_vec++;
      if (!seen) begin
         n_bad++;
         $display("FAIL done_timeout got no done within %0d cycles required done", bound);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got no finish required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.repeat_req = 1'b0; bus.address = 8'h00; bus.command = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_env", int'(bus.ir_env), 1);
      check("rst_led", int'(bus.ir_led), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Full frame 0xED12FF00: 16 ones -> (16+8+64+16*2+1+2)*4 = 492 busy cycles.
      pulse(1'b0, 1'b1, 1'b0, 8'h00, 8'h12);
      wait_done(2000);
      check("frame_total", m_total, 492);
      check("lead_mark", m_runs[0], 64);
      check("lead_space", m_runs[1], 32);
      check("bit0_mark", m_runs[2], 4);
      check("bit0_space", m_runs[3], 4);
      @(negedge clk);
      check("done_one_cycle", int'(bus.done), 0);

      pulse(1'b0, 1'b0, 1'b1, 8'h77, 8'h88);
      wait_done(2000);
      check("rep_total", m_total, 92);
      check("rep_lead", m_runs[0], 64);
      check("rep_space", m_runs[1], 16);
      check("rep_stop", m_runs[2], 4);
      check("rep_gap", m_runs[3], 8);

      // Simultaneous start and repeat: a full frame, bit 0 of 0xA5 is 1.
      pulse(1'b0, 1'b1, 1'b1, 8'hA5, 8'h3C);
      wait_done(2000);
      check("both_total", m_total, 492);
      check("both_bit0_space", m_runs[3], 12);

      // Start arriving mid-frame is dropped; the model keeps the original bits.
      pulse(1'b0, 1'b1, 1'b0, 8'h00, 8'h1A);
      repeat (180) @(negedge clk);
      pulse(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF);
      check("busy_mid", int'(bus.busy), 1);
      wait_done(2000);

      // Reset mid-bit aborts at once with no done pulse.
      pulse(1'b0, 1'b1, 1'b0, 8'h33, 8'h44);
      repeat (200) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      check("abort_env", int'(bus.ir_env), 1);
      check("abort_led", int'(bus.ir_led), 0);
      check("abort_busy", int'(bus.busy), 0);
      check("abort_done", int'(bus.done), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // Back-to-back: a new start presented in the done cycle is accepted.
      pulse(1'b0, 1'b1, 1'b0, 8'h00, 8'h1A);
      wait_done(2000);
      pulse(1'b1, 1'b1, 1'b0, 8'h5A, 8'hC3);
      wait_done(2000);
      check("b2b_total", m_total, 492);
      check("b2b_bit0_space", m_runs[3], 4);

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
